reg_wb_arbiter: RTL

- Shares the register file's single write port (IN/INADDRESS/WRITE) between two writeback sources: the ALU result path and the data-memory load-return path.
- The ALU side uses a valid/ready handshake, and the CPU stalls while ready is low.
- The memory side cannot be stalled, so it is buffered in a small FIFO.
- Bounded-wait priority keeps the ALU from starving. Output is registered and drives the register file directly; a pending-address mask is exported for hazard control.

---
 rtl/reg_wb_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/reg_wb_arbiter.sv
// Arbitrates the register-file write port between the ALU writeback handshake
// and a small FIFO of load returns; output is registered and drives the RF directly.
module reg_wb_arbiter #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 3
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     ALU_VALID,
    input  logic [ADDR_W-1:0]        ALU_ADDR,
    input  logic [DATA_W-1:0]        ALU_DATA,
    output logic                     ALU_READY,
    input  logic                     MEM_VALID,
    input  logic [ADDR_W-1:0]        MEM_ADDR,
    input  logic [DATA_W-1:0]        MEM_DATA,
    output logic                     WB_WRITE,
    output logic [ADDR_W-1:0]        WB_ADDR,
    output logic [DATA_W-1:0]        WB_DATA,
    output logic                     OVERFLOW,
    output logic [(1<<ADDR_W)-1:0]   PENDING_MASK
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              ovf_q, ovf_d;
    logic              wb_write_q, wb_write_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic fifo_empty, fifo_full, wait_sat;
    logic grant_alu, grant_mem, push_req, do_push;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        wait_sat   = (wait_q == WAIT_W'(MAX_WAIT));
        grant_alu  = ALU_VALID && !RESET && (fifo_empty || wait_sat);
        grant_mem  = !grant_alu && !fifo_empty && !RESET;
        push_req   = MEM_VALID && !RESET;
        // A full FIFO still accepts a push when the head leaves in the same cycle
        do_push    = push_req && (!fifo_full || grant_mem);
    end

    assign ALU_READY = grant_alu;

    always_comb begin
        wr_ptr_d   = do_push   ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = grant_mem ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({do_push, grant_mem})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        wait_d     = '0;
        if (ALU_VALID && !grant_alu) begin
            wait_d = wait_sat ? wait_q : wait_q + WAIT_W'(1);
        end
        ovf_d      = ovf_q | (push_req && fifo_full && !grant_mem);
        wb_write_d = grant_alu | grant_mem;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (grant_alu) begin
            wb_addr_d = ALU_ADDR;
            wb_data_d = ALU_DATA;
        end else if (grant_mem) begin
            wb_addr_d = fifo_addr_q[rd_ptr_q];
            wb_data_d = fifo_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_q     <= '0;
            ovf_q      <= 1'b0;
            wb_write_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            ovf_q      <= ovf_d;
            wb_write_q <= wb_write_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the pointers and count
    always_ff @(posedge CLK) begin
        if (do_push) begin
            fifo_addr_q[wr_ptr_q] <= MEM_ADDR;
            fifo_data_q[wr_ptr_q] <= MEM_DATA;
        end
    end

    always_comb begin
        PENDING_MASK = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (CNT_W'(k) < count_q) begin
                PENDING_MASK[fifo_addr_q[rd_ptr_q + PTR_W'(k)]] = 1'b1;
            end
        end
        if (wb_write_q) begin
            PENDING_MASK[wb_addr_q] = 1'b1;
        end
    end

    assign WB_WRITE = wb_write_q;
    assign WB_ADDR  = wb_addr_q;
    assign WB_DATA  = wb_data_q;
    assign OVERFLOW = ovf_q;

endmodule
